data_mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port data_memory.
- Requester 0 is the core load/store unit; requester 1 is the program/data loader or a debug port.
- Serialises the accesses, drives the memory's write_en/addr/data_in, captures data_out and returns it to the winner.
- Round-robin arbitration, one outstanding access at a time.

---
 rtl/data_mem_arb_pkg.sv | 18 +
 rtl/data_mem_arbiter_rr_arb2.sv | 52 +++++
 rtl/data_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and default widths for the data memory arbiter.
// Build option: DATA_MEM_ARB_FIXED_PRIO_EN (see rr_arb2).
package data_mem_arb_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_WDATA_W = 16;
  localparam int DEF_RDATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way winner select with a last-winner pointer, updated when adv is high.
// Build option DATA_MEM_ARB_FIXED_PRIO_EN: requester 0 always wins a tie.
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic adv,
  output logic vld,
  output logic win
);

  logic last_winner_q;
  logic last_winner_d;
  logic tie_win;

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  assign tie_win = PORT0;
`else
  assign tie_win = ~last_winner_q;
`endif

  always_comb begin
    vld = req0 | req1;
    if (req0 && req1) begin
      win = tie_win;
    end else if (req1) begin
      win = PORT1;
    end else begin
      win = PORT0;
    end
  end

  always_comb begin
    last_winner_d = last_winner_q;
    if (adv && vld) begin
      last_winner_d = win;
    end
  end

  // Reset to 1 so that requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_q <= PORT1;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory; one access in flight.
// Build option DATA_MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int WDATA_W = DEF_WDATA_W,
  parameter int RDATA_W = DEF_RDATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               we0,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [WDATA_W-1:0] wdata0,
  input  logic               req1,
  input  logic               we1,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [WDATA_W-1:0] wdata1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic [RDATA_W-1:0] rdata0,
  output logic [RDATA_W-1:0] rdata1,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  input  logic [RDATA_W-1:0] mem_rdata
);

  state_e state_q, state_d;

  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [WDATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               rvalid0_q, rvalid0_d;
  logic               rvalid1_q, rvalid1_d;
  logic [RDATA_W-1:0] rdata0_q, rdata0_d;
  logic [RDATA_W-1:0] rdata1_q, rdata1_d;
  logic               win_q, win_d;

  logic arb_vld;
  logic arb_win;
  logic arb_adv;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .adv   (arb_adv),
    .vld   (arb_vld),
    .win   (arb_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (arb_vld) state_d = ST_ACCESS;
      ST_ACCESS: state_d = mem_we_q ? ST_IDLE : ST_RDWAIT;
      ST_RDWAIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arb_adv     = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    win_d       = win_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          // The winner's command is captured here, so it may change once gnt is seen.
          arb_adv     = 1'b1;
          win_d       = arb_win;
          mem_we_d    = arb_win ? we1 : we0;
          mem_addr_d  = arb_win ? addr1 : addr0;
          mem_wdata_d = arb_win ? wdata1 : wdata0;
          gnt0_d      = (arb_win == PORT0);
          gnt1_d      = (arb_win == PORT1);
        end
      end
      ST_RDWAIT: begin
        if (win_q == PORT1) begin
          rvalid1_d = 1'b1;
          rdata1_d  = mem_rdata;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      win_q       <= PORT0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      win_q       <= win_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter with a behavioural 1-cycle-latency data memory.
// Honours DATA_MEM_ARB_FIXED_PRIO_EN when predicting contention order.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [7:0]  rdata0, rdata1, mem_rdata;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_clr = 1'b1;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata[7:0];
    end
    mem_rdata <= mem[mem_addr[7:0]];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  logic [7:0] shadow [256];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  int         gnt_log [$];
  int         gnt0_cnt = 0, gnt1_cnt = 0, rvalid0_cnt = 0, rvalid1_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt0) begin gnt0_cnt++; gnt_log.push_back(0); end
      if (gnt1) begin gnt1_cnt++; gnt_log.push_back(1); end
      if (rvalid0) begin
        rvalid0_cnt++;
        if (exp_q0.size() > 0) check_eq("rdata0", {24'd0, rdata0}, {24'd0, exp_q0.pop_front()});
        else check_eq("rvalid0_extra", {31'd0, rvalid0}, 32'd0);
      end
      if (rvalid1) begin
        rvalid1_cnt++;
        if (exp_q1.size() > 0) check_eq("rdata1", {24'd0, rdata1}, {24'd0, exp_q1.pop_front()});
        else check_eq("rvalid1_extra", {31'd0, rvalid1}, 32'd0);
      end
    end
  end

  // Call at posedge+1; returns with the grant visible (lat = cycles from sampling).
  task automatic issue(input bit port, input bit we, input logic [15:0] addr,
                       input logic [15:0] wd, output int lat);
    if (we) shadow[addr[7:0]] = wd[7:0];
    else if (port) exp_q1.push_back(shadow[addr[7:0]]);
    else exp_q0.push_back(shadow[addr[7:0]]);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!(port ? gnt1 : gnt0) && lat < 20);
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_rvalid(input bit port, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(port ? rvalid1 : rvalid0) && n < 20);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int lat, rv, bad, g0, r0, l0, w0, l1, w1;
  int exp_order [4];

  initial begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 256; i++) shadow[i] = '0;

    // Reset values
    tick(3);
    check_eq("rst_gnt0", {31'd0, gnt0}, 0);
    check_eq("rst_gnt1", {31'd0, gnt1}, 0);
    check_eq("rst_rvalid0", {31'd0, rvalid0}, 0);
    check_eq("rst_rvalid1", {31'd0, rvalid1}, 0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 0);
    check_eq("rst_mem_addr", {16'd0, mem_addr}, 0);
    check_eq("rst_mem_wdata", {16'd0, mem_wdata}, 0);
    check_eq("rst_rdata0", {24'd0, rdata0}, 0);
    check_eq("rst_rdata1", {24'd0, rdata1}, 0);
    rst_n = 1'b1;
    mem_clr = 1'b0;
    bad = 0;
    repeat (10) begin tick(1); if (mem_we || gnt0 || gnt1) bad++; end
    check_eq("idle_quiet", bad, 0);

    // Port 0 write, then change wdata after the grant
    issue(0, 1, 16'd2, 16'd25, lat);
    check_eq("wr0_gnt_lat", lat, 1);
    check_eq("wr0_mem_we", {31'd0, mem_we}, 1);
    check_eq("wr0_mem_addr", {16'd0, mem_addr}, 2);
    check_eq("wr0_mem_wdata", {16'd0, mem_wdata}, 25);
    wdata0 = 16'd99;
    tick(1);
    check_eq("wr0_we_one_cycle", {31'd0, mem_we}, 0);
    check_eq("wr0_wdata_hold", {16'd0, mem_wdata}, 25);

    // Port 0 read back
    issue(0, 0, 16'd2, 16'd0, lat);
    check_eq("rd0_gnt_lat", lat, 1);
    check_eq("rd0_mem_we", {31'd0, mem_we}, 0);
    wait_rvalid(0, rv);
    check_eq("rd0_rvalid_lat", lat + rv, 3);
    tick(3);
    check_eq("rd0_rdata_held", {24'd0, rdata0}, 25);

    // Port 1 path
    g0 = gnt0_cnt; r0 = rvalid0_cnt;
    issue(1, 1, 16'd5, 16'd50, lat);
    check_eq("wr1_gnt_lat", lat, 1);
    check_eq("wr1_mem_addr", {16'd0, mem_addr}, 5);
    tick(1);
    issue(1, 0, 16'd5, 16'd0, lat);
    check_eq("rd1_gnt_lat", lat, 1);
    wait_rvalid(1, rv);
    check_eq("rd1_rvalid_lat", lat + rv, 3);
    tick(2);
    check_eq("rd1_rdata_held", {24'd0, rdata1}, 50);
    check_eq("p1_no_gnt0", gnt0_cnt, g0);
    check_eq("p1_no_rvalid0", rvalid0_cnt, r0);

    // Contention: both ports issue two reads back to back
    gnt_log.delete();
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          issue(0, 0, 16'd2, 16'd0, l0);
          wait_rvalid(0, w0);
          check_eq("cont_rv0_lat", w0, 2);
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          issue(1, 0, 16'd5, 16'd0, l1);
          wait_rvalid(1, w1);
          check_eq("cont_rv1_lat", w1, 2);
        end
      end
    join
    check_eq("cont_gnt_count", gnt_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gnt_log.size()) check_eq($sformatf("cont_order%0d", k), gnt_log[k], exp_order[k]);
    end

    // Reset during the ACCESS cycle of a write
    tick(1);
    g0 = gnt0_cnt; r0 = rvalid0_cnt;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'd7; wdata0 = 16'd77;
    tick(1);
    check_eq("abort_in_access", {31'd0, mem_we}, 1);
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    check_eq("abort_mem_we", {31'd0, mem_we}, 0);
    check_eq("abort_gnt0", {31'd0, gnt0}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_eq("abort_no_gnt", gnt0_cnt, g0);
    check_eq("abort_no_rvalid", rvalid0_cnt, r0);
    issue(0, 0, 16'd7, 16'd0, lat);
    check_eq("abort_idle_lat", lat, 1);
    wait_rvalid(0, rv);
    check_eq("abort_rd_lat", rv, 2);
    tick(1);
    check_eq("abort_rdata_not77", {31'd0, (rdata0 != 8'd77)}, 1);

    tick(3);
    check_eq("queues_drained", exp_q0.size() + exp_q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
